// File: rtl/paicore_xfer_sched_if.sv
// Host/engine-facing bundle for the PAICORE transfer phase scheduler.
// Master drives configuration and engine pulses; slave is the scheduler itself.
interface paicore_xfer_sched_if #(
  parameter int unsigned All_Channel = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GUARD_W     = 8
);
  logic                   start;
  logic                   abort;
  logic [All_Channel-1:0] send_mask;
  logic                   recv_en;
  logic [CNT_W-1:0]       n_timestep;
  logic [GUARD_W-1:0]     guard_cycles;
  logic [CNT_W-1:0]       rx_timeout;
  logic                   tx_done;
  logic                   rx_done;
  logic [All_Channel-1:0] oen;
  logic                   send_go;
  logic                   recv_go;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic                   timeout_flag;
  logic [CNT_W-1:0]       step_cnt;
  logic [2:0]             state;

  modport master (
    output start, abort, send_mask, recv_en, n_timestep, guard_cycles, rx_timeout,
    output tx_done, rx_done,
    input  oen, send_go, recv_go, busy, done, aborted, timeout_flag, step_cnt, state
  );

  modport slave (
    input  start, abort, send_mask, recv_en, n_timestep, guard_cycles, rx_timeout,
    input  tx_done, rx_done,
    output oen, send_go, recv_go, busy, done, aborted, timeout_flag, step_cnt, state
  );
endinterface

// File: rtl/paicore_xfer_sched.sv
// Timestep phase scheduler: SEND -> guard -> RECV -> guard, with pad direction control,
// receive timeout and done/abort reporting. All outputs are registered from next state.
module paicore_xfer_sched #(
  parameter int unsigned All_Channel = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GUARD_W     = 8
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_aresetn,
  paicore_xfer_sched_if.slave  bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSend    = 3'd1;
  localparam logic [2:0] StGuardTx = 3'd2;
  localparam logic [2:0] StRecv    = 3'd3;
  localparam logic [2:0] StGuardRx = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [All_Channel-1:0] mask_q, mask_d;
  logic                   recv_en_q, recv_en_d;
  logic [CNT_W-1:0]       n_ts_q, n_ts_d;
  logic [GUARD_W-1:0]     guard_len_q, guard_len_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic [GUARD_W-1:0]     guard_cnt_q, guard_cnt_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]       step_q, step_d;
  logic                   tflag_q, tflag_d;
  logic                   abort_hit;

  logic [All_Channel-1:0] oen_q;
  logic                   send_go_q, recv_go_q, busy_q, done_q, aborted_q;

  logic [GUARD_W-1:0] guard_term;
  logic [CNT_W-1:0]   step_inc;

  // Guard of 0 behaves as 1 cycle: terminal count is 0 in both cases.
  assign guard_term = (guard_len_q == '0) ? '0 : guard_len_q - GUARD_W'(1);
  assign step_inc   = step_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    recv_en_d   = recv_en_q;
    n_ts_d      = n_ts_q;
    guard_len_d = guard_len_q;
    tmo_d       = tmo_q;
    guard_cnt_d = guard_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    step_d      = step_q;
    tflag_d     = tflag_q;
    abort_hit   = 1'b0;

    if (state_q != StIdle && bus.abort) begin
      state_d   = StIdle;
      abort_hit = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mask_d      = bus.send_mask;
            recv_en_d   = bus.recv_en;
            n_ts_d      = bus.n_timestep;
            guard_len_d = bus.guard_cycles;
            tmo_d       = bus.rx_timeout;
            step_d      = '0;
            tflag_d     = 1'b0;
            state_d     = (bus.n_timestep == '0) ? StDone : StSend;
          end
        end
        StSend: begin
          if (bus.tx_done) begin
            guard_cnt_d = '0;
            state_d     = StGuardTx;
          end
        end
        StGuardTx: begin
          if (guard_cnt_q == guard_term) begin
            if (recv_en_q) begin
              rx_cnt_d = '0;
              state_d  = StRecv;
            end else begin
              step_d  = step_inc;
              state_d = (step_inc == n_ts_q) ? StDone : StSend;
            end
          end else begin
            guard_cnt_d = guard_cnt_q + GUARD_W'(1);
          end
        end
        StRecv: begin
          if (bus.rx_done) begin
            guard_cnt_d = '0;
            state_d     = StGuardRx;
          end else if (tmo_q != '0 && rx_cnt_q == tmo_q - CNT_W'(1)) begin
            tflag_d = 1'b1;
            state_d = StDone;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
        StGuardRx: begin
          if (guard_cnt_q == guard_term) begin
            step_d  = step_inc;
            state_d = (step_inc == n_ts_q) ? StDone : StSend;
          end else begin
            guard_cnt_d = guard_cnt_q + GUARD_W'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      recv_en_q   <= 1'b0;
      n_ts_q      <= '0;
      guard_len_q <= '0;
      tmo_q       <= '0;
      guard_cnt_q <= '0;
      rx_cnt_q    <= '0;
      step_q      <= '0;
      tflag_q     <= 1'b0;
      oen_q       <= '0;
      send_go_q   <= 1'b0;
      recv_go_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      recv_en_q   <= recv_en_d;
      n_ts_q      <= n_ts_d;
      guard_len_q <= guard_len_d;
      tmo_q       <= tmo_d;
      guard_cnt_q <= guard_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      step_q      <= step_d;
      tflag_q     <= tflag_d;
      // Pads drive only in SEND, so oen and recv_go can never overlap.
      oen_q       <= (state_d == StSend) ? mask_d : '0;
      send_go_q   <= (state_d == StSend);
      recv_go_q   <= (state_d == StRecv);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      aborted_q   <= abort_hit;
    end
  end

  assign bus.oen          = oen_q;
  assign bus.send_go      = send_go_q;
  assign bus.recv_go      = recv_go_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.step_cnt     = step_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_paicore_xfer_sched.sv
// Directed bench for paicore_xfer_sched; done/abort pulses are matched against a
// scoreboard queue of expected completions.
module tb_paicore_xfer_sched;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  typedef struct packed {
    logic        is_abort;
    logic [31:0] step;
    logic        tflag;
  } exp_t;

  exp_t exp_q[$];
  bit   overlap_seen;
  bit   oen_bad;
  bit   recv_seen;

  paicore_xfer_sched_if #(.All_Channel(4), .CNT_W(32), .GUARD_W(8)) bus ();

  paicore_xfer_sched #(.All_Channel(4), .CNT_W(32), .GUARD_W(8)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive cycles spent in st, starting from the current observation.
  task automatic count_state(input logic [2:0] st, input int max_cyc, output int n);
    n = 0;
    while (bus.state === st && n < max_cyc) begin
      n++;
      step();
    end
  endtask

  // Accepts a run, then scrambles the config inputs to prove they were latched.
  task automatic kick(input logic [3:0] mask, input logic recv, input logic [31:0] n,
                      input logic [7:0] g, input logic [31:0] tmo);
    bus.send_mask    = mask;
    bus.recv_en      = recv;
    bus.n_timestep   = n;
    bus.guard_cycles = g;
    bus.rx_timeout   = tmo;
    bus.start        = 1'b1;
    step();
    bus.start        = 1'b0;
    bus.send_mask    = ~mask;
    bus.recv_en      = ~recv;
    bus.n_timestep   = n + 3;
    bus.guard_cycles = g + 5;
    bus.rx_timeout   = tmo + 7;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.oen != 4'b0 && bus.recv_go) overlap_seen = 1'b1;
      if (bus.oen != 4'b0 && bus.state != 3'd1) oen_bad = 1'b1;
      if (bus.recv_go) recv_seen = 1'b1;
      if (bus.done || bus.aborted) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'b0, bus.done, bus.aborted}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_done",    {31'b0, bus.done},         {31'b0, ~e.is_abort});
          chk("sb_aborted", {31'b0, bus.aborted},      {31'b0, e.is_abort});
          chk("sb_step",    bus.step_cnt,              e.step);
          chk("sb_tflag",   {31'b0, bus.timeout_flag}, {31'b0, e.tflag});
        end
      end
    end
  end

  initial begin
    int n;
    errors = 0;
    checks = 0;
    overlap_seen = 1'b0;
    oen_bad = 1'b0;
    recv_seen = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.send_mask = '0;
    bus.recv_en = 1'b0;
    bus.n_timestep = '0;
    bus.guard_cycles = '0;
    bus.rx_timeout = '0;
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {29'b0, bus.state}, 32'd0);
    chk("rst_oen", {28'b0, bus.oen}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_step", bus.step_cnt, 32'd0);
    chk("rst_tflag", {31'b0, bus.timeout_flag}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic run: two full timesteps with 3-cycle guards.
    exp_q.push_back('{is_abort: 1'b0, step: 32'd2, tflag: 1'b0});
    kick(4'b0101, 1'b1, 32'd2, 8'd3, 32'd0);
    for (int ts = 0; ts < 2; ts++) begin
      chk("t1_send", {29'b0, bus.state}, 32'd1);
      chk("t1_oen", {28'b0, bus.oen}, 32'h5);
      chk("t1_send_go", {31'b0, bus.send_go}, 32'd1);
      repeat (4) step();
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      count_state(3'd2, 20, n);
      chk("t1_gtx_len", n, 32'd3);
      chk("t1_recv", {29'b0, bus.state}, 32'd3);
      chk("t1_recv_go", {31'b0, bus.recv_go}, 32'd1);
      repeat (6) step();
      bus.rx_done = 1'b1;
      step();
      bus.rx_done = 1'b0;
      count_state(3'd4, 20, n);
      chk("t1_grx_len", n, 32'd3);
      chk("t1_step", bus.step_cnt, ts + 1);
    end
    chk("t1_done_state", {29'b0, bus.state}, 32'd5);
    chk("t1_done_busy", {31'b0, bus.busy}, 32'd1);
    step();
    chk("t1_idle", {29'b0, bus.state}, 32'd0);

    // Send-only with zero guard: each guard still lasts one cycle.
    recv_seen = 1'b0;
    exp_q.push_back('{is_abort: 1'b0, step: 32'd3, tflag: 1'b0});
    kick(4'b0011, 1'b0, 32'd3, 8'd0, 32'd0);
    for (int ts = 0; ts < 3; ts++) begin
      chk("t2_send", {29'b0, bus.state}, 32'd1);
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      count_state(3'd2, 5, n);
      chk("t2_gtx_len", n, 32'd1);
      chk("t2_step", bus.step_cnt, ts + 1);
    end
    chk("t2_done_state", {29'b0, bus.state}, 32'd5);
    step();
    chk("t2_no_recv", {31'b0, recv_seen}, 32'd0);

    // Receive timeout after exactly 10 RECV cycles.
    exp_q.push_back('{is_abort: 1'b0, step: 32'd0, tflag: 1'b1});
    kick(4'b0001, 1'b1, 32'd1, 8'd1, 32'd10);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    count_state(3'd2, 5, n);
    count_state(3'd3, 30, n);
    chk("t3_recv_len", n, 32'd10);
    chk("t3_done_state", {29'b0, bus.state}, 32'd5);
    chk("t3_tflag", {31'b0, bus.timeout_flag}, 32'd1);
    step();

    // Zero timesteps: DONE straight away, and the accepted start clears the timeout flag.
    exp_q.push_back('{is_abort: 1'b0, step: 32'd0, tflag: 1'b0});
    kick(4'b1111, 1'b1, 32'd0, 8'd2, 32'd0);
    chk("t5_zero_done", {29'b0, bus.state}, 32'd5);
    chk("t5_tflag_clr", {31'b0, bus.timeout_flag}, 32'd0);
    chk("t5_zero_oen", {28'b0, bus.oen}, 32'd0);
    step();

    // Start while busy is ignored; abort beats tx_done in the same cycle.
    exp_q.push_back('{is_abort: 1'b1, step: 32'd1, tflag: 1'b0});
    kick(4'b1010, 1'b0, 32'd5, 8'd0, 32'd0);
    bus.start = 1'b1;
    bus.n_timestep = 32'd1;
    step();
    bus.start = 1'b0;
    chk("t5_busy_start", {29'b0, bus.state}, 32'd1);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    count_state(3'd2, 5, n);
    chk("t5_latched_n", {29'b0, bus.state}, 32'd1);
    chk("t4_pre_step", bus.step_cnt, 32'd1);
    bus.abort = 1'b1;
    bus.tx_done = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.tx_done = 1'b0;
    chk("t4_state", {29'b0, bus.state}, 32'd0);
    chk("t4_oen", {28'b0, bus.oen}, 32'd0);
    chk("t4_send_go", {31'b0, bus.send_go}, 32'd0);
    chk("t4_aborted", {31'b0, bus.aborted}, 32'd1);
    chk("t4_no_done", {31'b0, bus.done}, 32'd0);
    chk("t4_step", bus.step_cnt, 32'd1);
    bus.abort = 1'b1;
    bus.tx_done = 1'b1;
    bus.rx_done = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b0;
    chk("t5_idle_abort", {31'b0, bus.aborted}, 32'd0);
    chk("t5_idle_stray", {29'b0, bus.state}, 32'd0);

    // Asynchronous reset mid-SEND releases the pads without a clock edge.
    kick(4'b0110, 1'b1, 32'd4, 8'd2, 32'd0);
    chk("t5_send_oen", {28'b0, bus.oen}, 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arst_oen", {28'b0, bus.oen}, 32'd0);
    chk("t5_arst_state", {29'b0, bus.state}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // rx_done on the final timeout cycle wins over the timeout.
    exp_q.push_back('{is_abort: 1'b1, step: 32'd1, tflag: 1'b0});
    kick(4'b1100, 1'b1, 32'd2, 8'd1, 32'd4);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    count_state(3'd2, 5, n);
    chk("t6_recv", {29'b0, bus.state}, 32'd3);
    repeat (3) step();
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    chk("t6_grx", {29'b0, bus.state}, 32'd4);
    chk("t6_tflag", {31'b0, bus.timeout_flag}, 32'd0);
    step();
    chk("t6_send", {29'b0, bus.state}, 32'd1);
    chk("t6_step", bus.step_cnt, 32'd1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();

    chk("sb_empty", exp_q.size(), 32'd0);
    chk("oen_recv_overlap", {31'b0, overlap_seen}, 32'd0);
    chk("oen_outside_send", {31'b0, oen_bad}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
